// File: rtl/stopwatch_core.sv
// Stopwatch control core: start/stop key edge detect, CLEAR/RUN/STOP FSM and
// a prescaled BCD mm:ss counter with registered tick/wrap pulses.
module stopwatch_core #(
   parameter int unsigned CLK_DIV = 10000000,
   parameter int unsigned PW      = $clog2(CLK_DIV)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_sync,
   output logic [2:0] mode,
   output logic       running,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       tick,
   output logic       wrap
);

   localparam logic [2:0]    ST_CLEAR   = 3'b100;
   localparam logic [2:0]    ST_RUN     = 3'b001;
   localparam logic [2:0]    ST_STOP    = 3'b010;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic          key_q;
   logic          press_c;
   logic          inc_c;
   logic [2:0]    mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
   logic          running_q, running_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

   assign press_c = key_sync & ~key_q;

   // State register and key edge register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q  <= 1'b0;
         mode_q <= ST_CLEAR;
      end else begin
         key_q  <= key_sync;
         mode_q <= mode_d;
      end
   end

   // Next-state: one step around the ring per press; anything non-one-hot recovers to CLEAR
   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         ST_CLEAR: if (press_c) mode_d = ST_RUN;
         ST_RUN:   if (press_c) mode_d = ST_STOP;
         ST_STOP:  if (press_c) mode_d = ST_CLEAR;
         default:  mode_d = ST_CLEAR;
      endcase
   end

   // Output/datapath next values: count only while RUN, zero whenever heading into CLEAR
   always_comb begin
      presc_d   = presc_q;
      so_d      = so_q;
      st_d      = st_q;
      mo_d      = mo_q;
      mt_d      = mt_q;
      inc_c     = (mode_q == ST_RUN) && (presc_q == PRESC_LAST);
      tick_d    = inc_c;
      wrap_d    = inc_c && (so_q == 4'd9) && (st_q == 4'd5) &&
                  (mo_q == 4'd9) && (mt_q == 4'd5);
      running_d = (mode_d == ST_RUN);
      if (mode_d == ST_CLEAR) begin
         presc_d = '0;
         so_d    = 4'd0;
         st_d    = 4'd0;
         mo_d    = 4'd0;
         mt_d    = 4'd0;
      end else if (mode_q == ST_RUN) begin
         presc_d = inc_c ? '0 : presc_q + PW'(1);
         if (inc_c) begin
            if (so_q == 4'd9) begin
               so_d = 4'd0;
               if (st_q == 4'd5) begin
                  st_d = 4'd0;
                  if (mo_q == 4'd9) begin
                     mo_d = 4'd0;
                     mt_d = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
                  end else begin
                     mo_d = mo_q + 4'd1;
                  end
               end else begin
                  st_d = st_q + 4'd1;
               end
            end else begin
               so_d = so_q + 4'd1;
            end
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         so_q      <= 4'd0;
         st_q      <= 4'd0;
         mo_q      <= 4'd0;
         mt_q      <= 4'd0;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         so_q      <= so_d;
         st_q      <= st_d;
         mo_q      <= mo_d;
         mt_q      <= mt_d;
         running_q <= running_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

   assign mode     = mode_q;
   assign running  = running_q;
   assign sec_ones = so_q;
   assign sec_tens = st_q;
   assign min_ones = mo_q;
   assign min_tens = mt_q;
   assign tick     = tick_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a CLK_DIV=4 and a CLK_DIV=2 instance checked every cycle
// against a seconds-count model, plus a directed vector table and corner sequences.
module tb_stopwatch_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       key4, key2;
   logic [2:0] mode4, mode2;
   logic       run4, run2, tick4, tick2, wrap4, wrap2;
   logic [3:0] so4, st4, mo4, mt4, so2, st2, mo2, mt2;

   stopwatch_core #(.CLK_DIV(4)) u4 (
      .clk(clk), .rst(rst), .key_sync(key4), .mode(mode4), .running(run4),
      .sec_ones(so4), .sec_tens(st4), .min_ones(mo4), .min_tens(mt4),
      .tick(tick4), .wrap(wrap4));

   stopwatch_core #(.CLK_DIV(2)) u2 (
      .clk(clk), .rst(rst), .key_sync(key2), .mode(mode2), .running(run2),
      .sec_ones(so2), .sec_tens(st2), .min_ones(mo2), .min_tens(mt2),
      .tick(tick2), .wrap(wrap2));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int tick4_cnt = 0;

   // Model: mode 0=CLEAR 1=RUN 2=STOP, elapsed whole seconds and sub-second cycle count
   int m_mode [2];
   int m_secs [2];
   int m_pre  [2];
   int m_div  [2] = '{4, 2};
   bit m_prev [2];
   bit m_tick [2];
   bit m_wrap [2];

   typedef struct {
      bit          key;
      int          n;
      logic [2:0]  mode;
      logic [15:0] digits;
      bit          tick;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(bit k, int n, logic [2:0] m, logic [15:0] d, bit t);
      vec_t v;
      v.key = k; v.n = n; v.mode = m; v.digits = d; v.tick = t;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_secs[i] = 0; m_pre[i] = 0;
         m_prev[i] = 1'b0; m_tick[i] = 1'b0; m_wrap[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i, input bit key);
      bit press;
      press     = key && !m_prev[i];
      m_prev[i] = key;
      m_tick[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (m_mode[i] == 1) begin
         if (m_pre[i] == m_div[i] - 1) begin
            m_pre[i]  = 0;
            m_secs[i] = (m_secs[i] + 1) % 3600;
            m_tick[i] = 1'b1;
            m_wrap[i] = (m_secs[i] == 0);
         end else begin
            m_pre[i] = m_pre[i] + 1;
         end
      end
      if (press) begin
         m_mode[i] = (m_mode[i] + 1) % 3;
         if (m_mode[i] == 0) begin
            m_secs[i] = 0;
            m_pre[i]  = 0;
         end
      end
   endtask

   function automatic logic [21:0] exp_vec(input int i);
      int mm, ss;
      logic [2:0] mc;
      mm = m_secs[i] / 60;
      ss = m_secs[i] % 60;
      mc = (m_mode[i] == 0) ? 3'b100 : (m_mode[i] == 1) ? 3'b001 : 3'b010;
      return {mc, m_mode[i] == 1, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              m_tick[i], m_wrap[i]};
   endfunction

   function automatic logic [21:0] act_vec(input int i);
      if (i == 0) return {mode4, run4, mt4, mo4, st4, so4, tick4, wrap4};
      return {mode2, run2, mt2, mo2, st2, so2, tick2, wrap2};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock: drive keys at the falling edge, advance the model at the rising edge, check at the next falling edge
   task automatic step(input bit k4, input bit k2);
      key4 = k4;
      key2 = k2;
      @(posedge clk);
      model_edge(0, k4);
      model_edge(1, k2);
      @(negedge clk);
      if (tick4 === 1'b1) tick4_cnt++;
      check("u4_cycle", act_vec(0), exp_vec(0));
      check("u2_cycle", act_vec(1), exp_vec(1));
   endtask

   // Called at a falling edge; reset outputs are checked 1 ns after rst rises, well before any clk edge
   task automatic do_reset(input bit k4, input bit k2);
      rst  = 1'b1;
      key4 = k4;
      key2 = k2;
      #1;
      model_reset();
      check("u4_async_rst", act_vec(0), exp_vec(0));
      check("u2_async_rst", act_vec(1), exp_vec(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit r4, r2;
      rst  = 1'b1;
      key4 = 1'b0;
      key2 = 1'b0;
      model_reset();

      tbl[0]  = mk(1'b0, 50, 3'b100, 16'h0000, 1'b0);
      tbl[1]  = mk(1'b1,  1, 3'b001, 16'h0000, 1'b0);
      tbl[2]  = mk(1'b0,  3, 3'b001, 16'h0000, 1'b0);
      tbl[3]  = mk(1'b0,  1, 3'b001, 16'h0001, 1'b1);
      tbl[4]  = mk(1'b0,  1, 3'b001, 16'h0001, 1'b0);
      tbl[5]  = mk(1'b0,  1, 3'b001, 16'h0001, 1'b0);
      tbl[6]  = mk(1'b1,  1, 3'b010, 16'h0001, 1'b0);
      tbl[7]  = mk(1'b1, 29, 3'b010, 16'h0001, 1'b0);
      tbl[8]  = mk(1'b0,  1, 3'b010, 16'h0001, 1'b0);
      tbl[9]  = mk(1'b1,  1, 3'b100, 16'h0000, 1'b0);
      tbl[10] = mk(1'b0,  5, 3'b100, 16'h0000, 1'b0);
      tbl[11] = mk(1'b1,  1, 3'b001, 16'h0000, 1'b0);
      tbl[12] = mk(1'b1,  3, 3'b001, 16'h0000, 1'b0);
      tbl[13] = mk(1'b1,  1, 3'b001, 16'h0001, 1'b1);
      tbl[14] = mk(1'b0, 36, 3'b001, 16'h0010, 1'b1);
      tbl[15] = mk(1'b0,  3, 3'b001, 16'h0010, 1'b0);
      tbl[16] = mk(1'b1,  1, 3'b010, 16'h0011, 1'b1);
      tbl[17] = mk(1'b0, 10, 3'b010, 16'h0011, 1'b0);
      tbl[18] = mk(1'b1,  1, 3'b100, 16'h0000, 1'b0);

      @(negedge clk);
      do_reset(1'b0, 1'b0);

      // Directed vectors on the CLK_DIV=4 instance
      for (int i = 0; i < 19; i++) begin
         if (i == 11) tick4_cnt = 0;
         for (int c = 0; c < tbl[i].n; c++) step(tbl[i].key, 1'b0);
         check($sformatf("vec%0d", i), {1'b0, mode4, mt4, mo4, st4, so4, tick4, wrap4},
               {1'b0, tbl[i].mode, tbl[i].digits, tbl[i].tick, 1'b0});
         if (i == 14) check_int("tick_count_40cyc", tick4_cnt, 10);
      end

      // Key already high across reset release gives one press on the first edge
      do_reset(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("key_high_at_release", {19'd0, mode4}, {19'd0, 3'b001});
      repeat (8) step(1'b1, 1'b0);
      check("held_no_second_press", {19'd0, mode4}, {19'd0, 3'b001});

      // Reset asserted mid-RUN at 02:37
      do_reset(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (628) step(1'b0, 1'b0);
      check("run_0237", {4'd0, mt4, mo4, st4, so4, tick4, wrap4}, {4'd0, 16'h0237, 1'b1, 1'b0});
      repeat (2) step(1'b0, 1'b0);
      do_reset(1'b0, 1'b0);

      // Full-hour rollover on the CLK_DIV=2 instance
      step(1'b0, 1'b1);
      repeat (120) step(1'b0, 1'b0);
      check("carry_0100", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h0100, 1'b1, 1'b0});
      repeat (1080) step(1'b0, 1'b0);
      check("carry_1000", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h1000, 1'b1, 1'b0});
      repeat (5998) step(1'b0, 1'b0);
      check("reach_5959", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h5959, 1'b1, 1'b0});
      step(1'b0, 1'b0);
      check("pre_wrap", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h5959, 1'b0, 1'b0});
      step(1'b0, 1'b0);
      check("wrap_0000", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h0000, 1'b1, 1'b1});
      step(1'b0, 1'b0);
      check("wrap_one_cycle", {4'd0, mt2, mo2, st2, so2, tick2, wrap2}, {4'd0, 16'h0000, 1'b0, 1'b0});

      // Randomized key activity, checked each cycle against the model
      do_reset(1'b0, 1'b0);
      r4 = 1'b0;
      r2 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) r4 = ~r4;
         if ($urandom_range(0, 9) == 0) r2 = ~r2;
         step(r4, r2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the key synchronizer stage in the stopwatch datapath.
- Takes the synchronized start/stop key level and detects its rising edge.
- Steps a three-state control FSM that uses the same one-hot mode encoding as the key stage.
- Runs a prescaled BCD mm:ss counter whose digits feed the display/decoder stage.

Parameters:
- CLK_DIV, 10000000, clk cycles per 1 s tick; legal range >= 2.
- PW, $clog2(CLK_DIV), prescaler counter width; derived, do not override.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- key_sync  input  1  synchronized key level from the key synchronizer; glitch-free, in clk domain.
- mode  output  3  one-hot state: 3'b100 CLEAR, 3'b001 RUN, 3'b010 STOP.
- running  output  1  high while mode == RUN.
- sec_ones  output  4  BCD seconds units, 0-9.
- sec_tens  output  4  BCD seconds tens, 0-5.
- min_ones  output  4  BCD minutes units, 0-9.
- min_tens  output  4  BCD minutes tens, 0-5.
- tick  output  1  one-cycle pulse on each 1 s increment.
- wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 increment.

Behaviour:
- Reset (async assert, sync-free release):
  - mode=3'b100, running=0, all digits=0, tick=0, wrap=0.
  - Prescaler=0; edge register key_q=0.
- Edge detect:
  - key_q <= key_sync every cycle.
  - press = key_sync & ~key_q, combinational.
  - A held key gives exactly one press. A key already high when rst deasserts gives one press on the first clk edge.
- FSM, advancing on the clk edge where press=1:
  - CLEAR -> RUN -> STOP -> CLEAR.
  - Latency: mode changes on the same edge that samples the rising key_sync.
  - No other transitions exist. An illegal mode (non-one-hot) goes to CLEAR on the next edge.
- CLEAR: digits and prescaler held at 0; tick=0.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps to 0.
  - The edge where prescaler==CLK_DIV-1 increments the BCD count.
  - tick is registered and high in the cycle after that edge, aligned with the new digit values.
- BCD increment:
  - sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones.
  - min_ones 9->0 carries to min_tens; min_tens 5->0 with all lower digits rolling gives 00:00.
  - All digits update on the same edge.
  - wrap is high together with tick only on 59:59 -> 00:00.
- STOP: digits and prescaler frozen, so partial-second progress is kept. STOP -> CLEAR zeroes them on the transition edge.
- CLEAR -> RUN: prescaler starts at 0; first tick exactly CLK_DIV cycles after the mode change edge.
- Simultaneous press and prescaler terminal count in RUN: the increment is applied on that edge (state is RUN during the cycle) and the FSM enters STOP on the same edge.
- rst mid-count: everything returns to reset values immediately, regardless of clk.
- All outputs are registered; no combinational path from key_sync to any output.

Test Plan (CLK_DIV=4 unless noted):
- Reset/idle: assert rst, release, hold key_sync=0 for 50 cycles -> mode=3'b100, digits 0:00:0:0, tick=0, wrap=0 throughout.
- Start and count: pulse key_sync high for 1 cycle -> mode=3'b001 on that edge. First tick exactly 4 cycles later with sec_ones=1. After 40 cycles in RUN: sec_tens=1, sec_ones=0, 10 tick pulses counted.
- Held key / single edge: hold key_sync high 20 cycles in CLEAR -> exactly one transition to RUN, no further mode change until key_sync drops and rises again.
- Stop/resume/clear:
  - RUN 6 cycles (sec_ones=1, prescaler=2), press -> mode=3'b010, digits frozen for 30 cycles.
  - Press -> mode=3'b100, all digits 0.
  - Press -> first tick 4 cycles later.
- Rollover (CLK_DIV=2): run 3600 ticks -> on tick 3600 the digits go 5,9,5,9 -> 0,0,0,0 with wrap=1 for exactly one cycle. Intermediate carries checked at 00:59 -> 01:00 and 09:59 -> 10:00.
- Boundary collisions:
  - Press on a prescaler terminal-count cycle -> count increments and mode=3'b010 on the same edge.
  - Assert rst mid-RUN at 02:37 -> outputs return to reset values asynchronously, before the next clk edge.
